// File: rtl/uart_pkg.sv
// Shared UART types used by the transmit controller.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

endpackage

// File: rtl/shift_register.sv
// Parallel-load, right-shifting register; serial_o presents the LSB first.
module shift_register #(
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_byte_i,
  input  logic          shift_i,
  input  logic [DW-1:0] data_i,
  output logic          serial_o
);

  logic [DW-1:0] sreg_q;

  // Load a new word, or move the next bit down to the output position.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sreg_q <= '0;
    end else if (load_byte_i) begin
      sreg_q <= data_i;
    end else if (shift_i) begin
      sreg_q <= {1'b0, sreg_q[DW-1:1]};
    end
  end

  assign serial_o = sreg_q[0];

endmodule

// File: rtl/uart_baud_gen.sv
// Bit-period counter: ticks on the last clock of every bit period.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic bit_tick_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] baud_cnt_q;

  // Held at zero while cleared so each frame starts on a fresh bit period.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      baud_cnt_q <= '0;
    end else if (clear_i || bit_tick_o) begin
      baud_cnt_q <= '0;
    end else begin
      baud_cnt_q <= baud_cnt_q + 1'b1;
    end
  end

  assign bit_tick_o = (baud_cnt_q == CW'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: start bit, LSB-first data, optional parity, stop bit(s).
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              tx_done_o
);

  localparam int BCW = $clog2(DATA_W + 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_ctrl: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
  end

  uart_tx_state_t state_q, state_d;
  logic [BCW-1:0] bit_cnt_q;
  logic           parity_q;
  logic           done_q;
  logic           bit_tick;
  logic           serial;
  logic           load_byte;
  logic           shift;
  logic           done_d;
  logic           bit_clr;
  logic           bit_inc;
  logic           last_data;
  logic           last_stop;

  assign last_data = (bit_cnt_q == BCW'(DATA_W - 1));
  assign last_stop = (bit_cnt_q == BCW'(STOP_BITS - 1));

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (state_q == IDLE),
    .bit_tick_o(bit_tick)
  );

  shift_register #(
    .DW(DATA_W)
  ) u_shift (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_byte_i(load_byte),
    .shift_i    (shift),
    .data_i     (tx_data_i),
    .serial_o   (serial)
  );

  // State, bit counter, captured parity and the registered done pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (bit_clr) begin
        bit_cnt_q <= '0;
      end else if (bit_inc) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      if (load_byte) begin
        parity_q <= (^tx_data_i) ^ (PARITY_ODD != 0);
      end
    end
  end

  // Next state, shift-register controls and the line mux; every move waits for bit_tick.
  always_comb begin
    state_d   = state_q;
    load_byte = 1'b0;
    shift     = 1'b0;
    done_d    = 1'b0;
    bit_clr   = 1'b0;
    bit_inc   = 1'b0;
    tx_o      = 1'b1;
    case (state_q)
      IDLE: begin
        if (tx_valid_i) begin
          load_byte = 1'b1;
          bit_clr   = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        tx_o = 1'b0;
        if (bit_tick) state_d = DATA;
      end
      DATA: begin
        tx_o = serial;
        if (bit_tick) begin
          shift = 1'b1;
          if (last_data) begin
            bit_clr = 1'b1;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
      PARITY: begin
        tx_o = parity_q;
        if (bit_tick) state_d = STOP;
      end
      STOP: begin
        tx_o = 1'b1;
        if (bit_tick) begin
          if (last_stop) begin
            bit_clr = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_ready_o = (state_q == IDLE);
  assign busy_o     = (state_q != IDLE);
  assign tx_done_o  = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: one plain instance and two parity instances.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       v0, v_pe, v_po;
  logic       ready0, tx0, busy0, done0;
  logic       ready_pe, tx_pe, busy_pe, done_pe;
  logic       ready_po, tx_po, busy_po, done_po;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk_i(clk), .rst_i(rst), .tx_data_i(tx_data), .tx_valid_i(v0),
    .tx_ready_o(ready0), .tx_o(tx0), .busy_o(busy0), .tx_done_o(done0));

  uart_tx_ctrl #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0)) dut_pe (
    .clk_i(clk), .rst_i(rst), .tx_data_i(tx_data), .tx_valid_i(v_pe),
    .tx_ready_o(ready_pe), .tx_o(tx_pe), .busy_o(busy_pe), .tx_done_o(done_pe));

  uart_tx_ctrl #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1)) dut_po (
    .clk_i(clk), .rst_i(rst), .tx_data_i(tx_data), .tx_valid_i(v_po),
    .tx_ready_o(ready_po), .tx_o(tx_po), .busy_o(busy_po), .tx_done_o(done_po));

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx0 !== 1'b1 || ready0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold actual tx=%b rdy=%b busy=%b done=%b required 1 1 0 0", tx0, ready0, busy0, done0);
    end
    rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      checks++;
      if (tx0 !== 1'b1 || ready0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0 ||
          tx_pe !== 1'b1 || tx_po !== 1'b1) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d actual tx=%b rdy=%b busy=%b done=%b txpe=%b txpo=%b required 1 1 0 0 1 1",
                 j, tx0, ready0, busy0, done0, tx_pe, tx_po);
      end
    end
  endtask

  task automatic test_basic_frame();
    logic [0:9] exp;
    logic       exp_tx;
    exp = 10'b0101001011;  // 0xA5: start, 1,0,1,0,0,1,0,1, stop
    @(negedge clk);
    tx_data = 8'hA5;
    v0 = 1'b1;
    checks++;
    if (ready0 !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready_pre actual=%b required=1", ready0);
    end
    @(posedge clk);
    for (int j = 0; j <= 44; j++) begin
      @(negedge clk);
      if (j == 0) v0 = 1'b0;
      exp_tx = (j < 40) ? exp[j/4] : 1'b1;
      checks++;
      if (tx0 !== exp_tx) begin
        errors++;
        $display("FAIL basic_tx cyc=%0d actual=%b required=%b", j, tx0, exp_tx);
      end
      checks++;
      if (done0 !== (j == 40) || ready0 !== (j >= 40) || busy0 !== (j < 40)) begin
        errors++;
        $display("FAIL basic_ctrl cyc=%0d actual done=%b rdy=%b busy=%b required %b %b %b",
                 j, done0, ready0, busy0, (j == 40), (j >= 40), (j < 40));
      end
    end
  endtask

  task automatic test_parity();
    logic [0:10] exp_e, exp_o;
    logic        te, to;
    exp_e = 11'b01110000011;  // 0x07, even parity bit 1
    exp_o = 11'b01110000001;  // 0x07, odd parity bit 0
    @(negedge clk);
    tx_data = 8'h07;
    v_pe = 1'b1;
    v_po = 1'b1;
    @(posedge clk);
    for (int j = 0; j <= 48; j++) begin
      @(negedge clk);
      if (j == 0) begin
        v_pe = 1'b0;
        v_po = 1'b0;
      end
      te = (j < 44) ? exp_e[j/4] : 1'b1;
      to = (j < 44) ? exp_o[j/4] : 1'b1;
      checks++;
      if (tx_pe !== te || tx_po !== to) begin
        errors++;
        $display("FAIL parity_tx cyc=%0d actual even=%b odd=%b required even=%b odd=%b", j, tx_pe, tx_po, te, to);
      end
      checks++;
      if (done_pe !== (j == 44) || done_po !== (j == 44) ||
          ready_pe !== (j >= 44) || ready_po !== (j >= 44) ||
          busy_pe !== (j < 44) || busy_po !== (j < 44)) begin
        errors++;
        $display("FAIL parity_ctrl cyc=%0d actual done=%b%b rdy=%b%b busy=%b%b required done=%b rdy=%b busy=%b",
                 j, done_pe, done_po, ready_pe, ready_po, busy_pe, busy_po, (j == 44), (j >= 44), (j < 44));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [0:9] exp_a, exp_b;
    logic       exp_tx;
    int         gap;
    bit         in_gap;
    exp_a = 10'b0000000001;  // 0x00
    exp_b = 10'b0111111111;  // 0xFF
    gap = 0;
    in_gap = 1'b0;
    @(negedge clk);
    tx_data = 8'h00;
    v0 = 1'b1;
    @(posedge clk);
    #1 tx_data = 8'hFF;
    for (int j = 0; j <= 85; j++) begin
      @(negedge clk);
      if (j == 41) v0 = 1'b0;
      if (j < 40)       exp_tx = exp_a[j/4];
      else if (j == 40) exp_tx = 1'b1;
      else if (j < 81)  exp_tx = exp_b[(j-41)/4];
      else              exp_tx = 1'b1;
      checks++;
      if (tx0 !== exp_tx) begin
        errors++;
        $display("FAIL b2b_tx cyc=%0d actual=%b required=%b", j, tx0, exp_tx);
      end
      checks++;
      if (done0 !== (j == 40 || j == 81) || ready0 !== (j == 40 || j >= 81)) begin
        errors++;
        $display("FAIL b2b_ctrl cyc=%0d actual done=%b rdy=%b required %b %b",
                 j, done0, ready0, (j == 40 || j == 81), (j == 40 || j >= 81));
      end
      if (j >= 36 && j <= 45) begin
        if (tx0 === 1'b1 && (j == 36 || in_gap)) begin
          in_gap = 1'b1;
          gap++;
        end else begin
          in_gap = 1'b0;
        end
      end
    end
    checks++;
    if (gap != 5) begin
      errors++;
      $display("FAIL b2b_gap actual=%0d required=5", gap);
    end
  endtask

  task automatic test_busy_ignore();
    logic [0:9] exp_a, exp_b;
    logic       exp_tx;
    exp_a = 10'b0010110101;  // 0x5A
    exp_b = 10'b0001111001;  // 0x3C
    @(negedge clk);
    tx_data = 8'h5A;
    v0 = 1'b1;
    @(posedge clk);
    for (int j = 0; j <= 48; j++) begin
      @(negedge clk);
      if (j == 0)  v0 = 1'b0;
      if (j == 10) begin
        tx_data = 8'h3C;
        v0 = 1'b1;
      end
      if (j == 11) v0 = 1'b0;
      exp_tx = (j < 40) ? exp_a[j/4] : 1'b1;
      checks++;
      if (tx0 !== exp_tx || done0 !== (j == 40) || ready0 !== (j >= 40)) begin
        errors++;
        $display("FAIL ignore_tx cyc=%0d actual tx=%b done=%b rdy=%b required %b %b %b",
                 j, tx0, done0, ready0, exp_tx, (j == 40), (j >= 40));
      end
    end
    @(negedge clk);
    tx_data = 8'h3C;
    v0 = 1'b1;
    @(posedge clk);
    for (int j = 0; j <= 42; j++) begin
      @(negedge clk);
      if (j == 0) v0 = 1'b0;
      exp_tx = (j < 40) ? exp_b[j/4] : 1'b1;
      checks++;
      if (tx0 !== exp_tx || done0 !== (j == 40)) begin
        errors++;
        $display("FAIL represent_tx cyc=%0d actual tx=%b done=%b required %b %b",
                 j, tx0, done0, exp_tx, (j == 40));
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [0:9] exp;
    logic       exp_tx;
    exp = 10'b0100000011;  // 0x81
    @(negedge clk);
    tx_data = 8'h00;
    v0 = 1'b1;
    @(posedge clk);
    for (int j = 0; j <= 17; j++) begin
      @(negedge clk);
      if (j == 0) v0 = 1'b0;
    end
    checks++;
    if (tx0 !== 1'b0 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre actual tx=%b busy=%b required 0 1", tx0, busy0);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (tx0 !== 1'b1 || ready0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async actual tx=%b rdy=%b busy=%b done=%b required 1 1 0 0", tx0, ready0, busy0, done0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tx0 !== 1'b1 || ready0 !== 1'b1) begin
      errors++;
      $display("FAIL midreset_post actual tx=%b rdy=%b required 1 1", tx0, ready0);
    end
    tx_data = 8'h81;
    v0 = 1'b1;
    @(posedge clk);
    for (int j = 0; j <= 42; j++) begin
      @(negedge clk);
      if (j == 0) v0 = 1'b0;
      exp_tx = (j < 40) ? exp[j/4] : 1'b1;
      checks++;
      if (tx0 !== exp_tx || done0 !== (j == 40) || ready0 !== (j >= 40)) begin
        errors++;
        $display("FAIL midreset_frame cyc=%0d actual tx=%b done=%b rdy=%b required %b %b %b",
                 j, tx0, done0, ready0, exp_tx, (j == 40), (j >= 40));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    tx_data = 8'h00;
    v0 = 1'b0;
    v_pe = 1'b0;
    v_po = 1'b0;
    test_reset();
    test_basic_frame();
    test_parity();
    test_back_to_back();
    test_busy_ignore();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
UART transmit controller. Accepts bytes over a valid/ready handshake and sequences the team's shift_register (load, then shift once per bit period). Frames each byte as start bit, DATA_W data bits (LSB first), optional parity bit and stop bit(s) on the serial line. Sits between the host-side byte source and the tx pin.

Parameters:
DATA_W, 8, data bits per frame; also the width of the instantiated shift_register.
CLKS_PER_BIT, 16, clk_i cycles per bit period; must be >= 2, elaboration error otherwise.
STOP_BITS, 1, number of stop bits; must be 1 or 2, elaboration error otherwise.
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.

Ports:
clk_i  in  1  clock.
rst_i  in  1  reset; asynchronous, active-high.
tx_data_i  in  DATA_W  byte to send; sampled only on an accept.
tx_valid_i  in  1  source has a byte.
tx_ready_o  out  1  controller can accept a byte.
tx_o  out  1  serial line; idle high.
busy_o  out  1  frame in progress.
tx_done_o  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (async, immediate): state=IDLE, counters=0, shift register cleared, parity reg=0, tx_o=1, tx_ready_o=1, busy_o=0, tx_done_o=0. Reset mid-frame abandons the frame; tx_o goes high without waiting for a clock edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- tx_ready_o = (state==IDLE). busy_o = (state!=IDLE).
- Accept = tx_valid_i & tx_ready_o at a rising edge. The same cycle drives shift_register load_byte_i=1. At that edge: parity reg <= ^tx_data_i ^ PARITY_ODD, baud_cnt<=0, bit_cnt<=0, state<=START.
- tx_valid_i while not ready is ignored. tx_data_i is not captured and in-flight data is not disturbed.
- Baud counter: width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1 in every non-IDLE state. bit_tick = (baud_cnt==CLKS_PER_BIT-1). Wraps to 0 on bit_tick.
- tx_o mux from registered state: IDLE=1, START=0, DATA=serial_o, PARITY=parity reg, STOP=1. Each bit is held exactly CLKS_PER_BIT cycles.
- Transitions on bit_tick:
  - START->DATA.
  - DATA: shift_i=1 on bit_tick (never otherwise). bit_cnt increments. On the tick with bit_cnt==DATA_W-1, go to PARITY if PARITY_EN, else STOP, and clear bit_cnt.
  - PARITY->STOP.
  - STOP: bit_cnt counts stop bits. On the tick with bit_cnt==STOP_BITS-1, go to IDLE and set tx_done_o=1 for exactly one cycle (the first IDLE cycle).
- load_byte_i and shift_i are never asserted together.
- Frame length from accept edge to the return to IDLE: (1+DATA_W+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
- Back-to-back: tx_ready_o is high in the IDLE cycle coinciding with tx_done_o. If tx_valid_i is held, the next byte is accepted there, so the line-high gap is STOP_BITS*CLKS_PER_BIT+1 cycles.
- bit_cnt width: $clog2(DATA_W+1).

Decomposition:
- Shared package uart_pkg holds the state enum type (uart_tx_state_t: IDLE, START, DATA, PARITY, STOP) and any frame-length localparam helpers.
- The block instantiates the existing shift_register (DW=DATA_W).
- One new sub-module is natural: uart_baud_gen (counter, bit_tick output, clear input).

Test Plan:
All cases use DATA_W=8, CLKS_PER_BIT=4, STOP_BITS=1.
1. Reset, then idle 10 cycles -> tx_o=1, tx_ready_o=1, busy_o=0, tx_done_o=0 throughout.
2. Send 0xA5, PARITY_EN=0 -> tx_o = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. tx_done_o pulses once, 40 cycles after the accept edge. tx_ready_o is low for cycles 1..39.
3. PARITY_EN=1, send 0x07 -> parity bit 1 with PARITY_ODD=0 and 0 with PARITY_ODD=1. Frame is 44 cycles.
4. Hold tx_valid_i with 0x00, then 0xFF immediately after the first accept -> second accepted in the tx_done_o cycle. Line-high gap between frames is exactly 5 cycles, and the second frame is correct.
5. Mid-frame, pulse tx_valid_i with 0x3C -> no accept; the current byte 0x5A is transmitted uncorrupted. 0x3C is sent only if re-presented after done.
6. Assert rst_i during DATA bit 3 -> tx_o=1 and tx_ready_o=1 immediately. After release, sending 0x81 produces the correct 40-cycle frame.
